// File: rtl/tdc_result_fifo_if.sv
// tdc_result_fifo_if: write strobe, read request, status and read data of the
// TDC result FIFO.
// Optional macro TDC_FIFO_DROP_CNT_EN adds the drop_cnt status bus.
interface tdc_result_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_valid;
  logic [3:0]            addr_in;
  logic [27:0]           data_in;
  logic                  rd_en;
  logic                  clr_ovf;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
`ifdef TDC_FIFO_DROP_CNT_EN
  logic [15:0]           drop_cnt;

  modport master (
    output wr_valid, addr_in, data_in, rd_en, clr_ovf,
    input  dout, dout_valid, empty, full, level, overflow, drop_cnt
  );

  modport slave (
    input  wr_valid, addr_in, data_in, rd_en, clr_ovf,
    output dout, dout_valid, empty, full, level, overflow, drop_cnt
  );
`else
  modport master (
    output wr_valid, addr_in, data_in, rd_en, clr_ovf,
    input  dout, dout_valid, empty, full, level, overflow
  );

  modport slave (
    input  wr_valid, addr_in, data_in, rd_en, clr_ovf,
    output dout, dout_valid, empty, full, level, overflow
  );
`endif
endinterface

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: 2**DEPTH_LOG2 x 32-bit FIFO buffering TDC result words
// {addr[3:0], data[27:0]} between the TDC read stage and a consumer.
// Writes arriving while full are dropped and flagged in the sticky overflow bit.
// Optional macro TDC_FIFO_DROP_CNT_EN adds a saturating 16-bit count of dropped writes.
module tdc_result_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  tdc_result_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_overflow;
  logic [31:0]           r_dout;
  logic                  r_dout_valid;

  logic                  w_wr_acc;
  logic                  w_wr_rej;
  logic                  w_rd_acc;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  // Accept decisions use the registered flags, so a same-cycle read never frees
  // room for a write that arrives while full.
  assign w_wr_acc = bus.wr_valid & ~r_full;
  assign w_wr_rej = bus.wr_valid &  r_full;
  assign w_rd_acc = bus.rd_en    & ~r_empty;

  // Next word count: simultaneous accepted read and write cancel out.
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + (DEPTH_LOG2+1)'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - (DEPTH_LOG2+1)'(1);
    end
  end

  // Storage array; contents are left untouched by reset since the pointers
  // already make any stale word unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= {bus.addr_in, bus.data_in};
    end
  end

  // Pointers, level and the registered empty/full flags derived from the next level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LVL_FULL);
    end
  end

  // Read port: oldest word appears one cycle after an accepted read; dout
  // holds its value otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
    end
  end

  // Sticky overflow: a rejected write takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_wr_rej) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef TDC_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of dropped writes; counting takes priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_wr_rej) begin
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (bus.clr_ovf) begin
      r_drop_cnt <= '0;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.empty      = r_empty;
  assign bus.full       = r_full;
  assign bus.level      = r_level;
  assign bus.overflow   = r_overflow;

endmodule
